iq_integrate_dump: RTL and testbench

- Downstream of the I/Q mixer in the BPSK demodulator chain.
- Takes the signed 16-bit I and Q products and integrates each over 2^DEC_LOG2 valid samples, then dumps.
- Each dump emits the decimated average of I and Q plus a hard BPSK bit decision taken from I.
- Acts as the low-pass/decimation stage ahead of symbol timing and carrier-loop logic.

---
 rtl/iq_dsp_pkg.sv | 31 +++
 rtl/iq_acc_channel.sv | 46 ++++
 rtl/iq_integrate_dump.sv | 70 +++++++
 tb/tb_iq_integrate_dump.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/iq_dsp_pkg.sv
// iq_dsp_pkg: shared width derivation, saturation and rounding helpers for the I/Q DSP chain.
// Values are handled in a 64-bit signed working width so one helper set serves any channel size.
package iq_dsp_pkg;

    localparam int SAT_W = 64;

    function automatic int acc_width(input int in_w, input int dec_log2);
        return in_w + dec_log2;
    endfunction

    function automatic int shift_amt(input int acc_w, input int out_w);
        return acc_w - out_w;
    endfunction

    function automatic int cnt_width(input int dec_log2);
        return dec_log2 > 0 ? dec_log2 : 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] half_lsb(input int sh);
        return sh > 0 ? 64'sd1 <<< (sh - 1) : 64'sd0;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_to(input logic signed [SAT_W-1:0] v, input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

endpackage

// File: rtl/iq_acc_channel.sv
// iq_acc_channel: single-channel integrator producing the scaled, saturated window sum.
// IQ_INTEGRATE_DUMP_ROUND_EN adds round-half-up ahead of the scaling shift.
module iq_acc_channel
    import iq_dsp_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 16,
    parameter int DEC_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    dump,
    input  logic signed [IN_W-1:0]  x,
    output logic signed [OUT_W-1:0] ys
);

    localparam int ACC_W = acc_width(IN_W, DEC_LOG2);
    localparam int SH    = shift_amt(ACC_W, OUT_W);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [SAT_W-1:0] wide;
    logic signed [SAT_W-1:0] scaled;

    assign sum = acc + ACC_W'(x);
`ifdef IQ_INTEGRATE_DUMP_ROUND_EN
    assign wide = SAT_W'(sum) + half_lsb(SH);
`else
    assign wide = SAT_W'(sum);
`endif
    // Arithmetic shift floors toward -inf; saturation catches a rounding carry.
    assign scaled = wide >>> SH;
    assign ys     = OUT_W'(sat_to(scaled, OUT_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clear || dump)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/iq_integrate_dump.sv
// iq_integrate_dump: I/Q integrate-and-dump decimator with hard BPSK decision on I.
// Define IQ_INTEGRATE_DUMP_ROUND_EN for round-half-up scaling instead of truncation.
module iq_integrate_dump
    import iq_dsp_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 16,
    parameter int DEC_LOG2 = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              in_valid,
    input  logic signed [IN_W-1:0]            i_in,
    input  logic signed [IN_W-1:0]            q_in,
    output logic                              out_valid,
    output logic signed [OUT_W-1:0]           i_out,
    output logic signed [OUT_W-1:0]           q_out,
    output logic                              sym_bit,
    output logic [cnt_width(DEC_LOG2)-1:0]    win_cnt
);

    localparam int CW = cnt_width(DEC_LOG2);
    localparam int N  = 1 << DEC_LOG2;

    logic [CW-1:0]           cnt;
    logic                    last;
    logic                    dump;
    logic signed [OUT_W-1:0] i_s;
    logic signed [OUT_W-1:0] q_s;

    assign last    = cnt == CW'(N - 1);
    assign dump    = in_valid && !clear && last;
    assign win_cnt = cnt;

    iq_acc_channel #(.IN_W(IN_W), .OUT_W(OUT_W), .DEC_LOG2(DEC_LOG2)) u_i (
        .clk(clk), .rst(rst), .clear(clear), .en(in_valid), .dump(dump), .x(i_in), .ys(i_s)
    );

    iq_acc_channel #(.IN_W(IN_W), .OUT_W(OUT_W), .DEC_LOG2(DEC_LOG2)) u_q (
        .clk(clk), .rst(rst), .clear(clear), .en(in_valid), .dump(dump), .x(q_in), .ys(q_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (in_valid)
            cnt <= last ? '0 : cnt + CW'(1);
    end

    // Results hold across clear and idle cycles; only a dump refreshes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            sym_bit   <= 1'b0;
        end else begin
            out_valid <= dump;
            if (dump) begin
                i_out   <= i_s;
                q_out   <= q_s;
                sym_bit <= ~i_s[OUT_W-1];
            end
        end
    end

endmodule

// File: tb/tb_iq_integrate_dump.sv
// tb_iq_integrate_dump: directed vectors for the integrate-and-dump decimator.
// Expected rounding results follow IQ_INTEGRATE_DUMP_ROUND_EN when it is defined.
module tb_iq_integrate_dump;

`ifdef IQ_INTEGRATE_DUMP_ROUND_EN
    localparam longint P24 = 2;
    localparam longint N24 = -1;
`else
    localparam longint P24 = 1;
    localparam longint N24 = -2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic signed [15:0] i_in = '0;
    logic signed [15:0] q_in = '0;
    logic out_valid;
    logic signed [15:0] i_out;
    logic signed [15:0] q_out;
    logic sym_bit;
    logic [3:0] win_cnt;

    logic v1 = 1'b0;
    logic clr1 = 1'b0;
    logic signed [15:0] i1 = '0;
    logic signed [15:0] q1 = '0;
    logic ov1;
    logic signed [7:0] i1o;
    logic signed [7:0] q1o;
    logic s1;
    logic [0:0] w1;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;
    int p;

    always #5 clk = ~clk;

    iq_integrate_dump dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .i_in(i_in), .q_in(q_in),
        .out_valid(out_valid), .i_out(i_out), .q_out(q_out), .sym_bit(sym_bit), .win_cnt(win_cnt)
    );

    iq_integrate_dump #(.IN_W(16), .OUT_W(8), .DEC_LOG2(0)) dut1 (
        .clk(clk), .rst(rst), .clear(clr1), .in_valid(v1), .i_in(i1), .q_in(q1),
        .out_valid(ov1), .i_out(i1o), .q_out(q1o), .sym_bit(s1), .win_cnt(w1)
    );

    always @(negedge clk) if (out_valid) pulses++;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic signed [15:0] i, input logic signed [15:0] q);
        in_valid = 1'b1;
        i_in = i;
        q_in = q;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_ov", out_valid, 0);
        check("rst_i", i_out, 0);
        check("rst_sym", sym_bit, 0);
        check("rst_cnt", win_cnt, 0);
        rst = 1'b0;
        idle(1);

        p = pulses;
        for (int k = 0; k < 16; k++) begin
            send(16'sd1000, -16'sd500);
            if (k == 14) begin
                check("t1_cnt15", win_cnt, 15);
                check("t1_early_ov", out_valid, 0);
            end
        end
        check("t1_ov", out_valid, 1);
        check("t1_i", i_out, 1000);
        check("t1_q", q_out, -500);
        check("t1_sym", sym_bit, 1);
        check("t1_cnt0", win_cnt, 0);
        idle(1);
        check("t1_ov_drop", out_valid, 0);
        check("t1_pulses", pulses - p, 1);

        p = pulses;
        for (int k = 0; k < 16; k++) begin
            send(16'h8000, 16'sd0);
            if (k < 15) idle(1);
            if (k == 14) check("t2_gap_nopulse", pulses - p, 0);
        end
        check("t2_ov", out_valid, 1);
        check("t2_i", i_out, -32768);
        check("t2_sym", sym_bit, 0);
        idle(1);
        check("t2_pulses", pulses - p, 1);

        send(16'sd24, 16'sd0);
        for (int k = 0; k < 15; k++) send(16'sd0, 16'sd0);
        check("t3_pos_i", i_out, P24);
        check("t3_pos_sym", sym_bit, 1);
        send(-16'sd24, 16'sd0);
        for (int k = 0; k < 15; k++) send(16'sd0, 16'sd0);
        check("t3_neg_i", i_out, N24);
        check("t3_neg_sym", sym_bit, 0);
        idle(1);

        p = pulses;
        for (int k = 0; k < 7; k++) send(16'sd5000, 16'sd0);
        clear = 1'b1;
        send(16'sd5000, 16'sd0);
        clear = 1'b0;
        check("t4_clr_cnt", win_cnt, 0);
        check("t4_clr_ov", out_valid, 0);
        check("t4_hold_i", i_out, N24);
        for (int k = 0; k < 16; k++) send(16'sd100, 16'sd0);
        check("t4_i", i_out, 100);
        idle(1);
        check("t4_pulses", pulses - p, 1);

        p = pulses;
        for (int k = 0; k < 9; k++) send(16'sd7, -16'sd7);
        check("t5_cnt9", win_cnt, 9);
        #3 rst = 1'b1;
        #1;
        check("t5_rst_i", i_out, 0);
        check("t5_rst_q", q_out, 0);
        check("t5_rst_sym", sym_bit, 0);
        check("t5_rst_cnt", win_cnt, 0);
        check("t5_rst_ov", out_valid, 0);
        #2 rst = 1'b0;
        for (int k = 0; k < 16; k++) send(16'sd7, -16'sd7);
        check("t5_i", i_out, 7);
        check("t5_q", q_out, -7);
        idle(1);
        check("t5_pulses", pulses - p, 1);

        check("t6_idle_ov", ov1, 0);
        v1 = 1'b1;
        i1 = 16'sd32767;
        q1 = 16'h8000;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        check("t6_ov", ov1, 1);
        check("t6_i_sat", i1o, 127);
        check("t6_q", q1o, -128);
        check("t6_sym", s1, 1);
        check("t6_cnt", w1, 0);
        idle(1);
        check("t6_ov_drop", ov1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
